// File: rtl/cpu_pkg.sv
// Shared decode/execute definitions for the 5-stage MIPS pipeline:
// immediate-extension encodings, well-known registers and the NOP control word.
package cpu_pkg;

   typedef enum logic [1:0] {
      EXT_ZERO  = 2'b00,
      EXT_SIGN  = 2'b01,
      EXT_LUI   = 2'b10,
      EXT_SHAMT = 2'b11
   } ext_op_e;

   localparam int unsigned REG_K0 = 26;
   localparam int unsigned REG_RA = 31;

   localparam int CTRL_W_DEFAULT = 16;
   localparam logic [CTRL_W_DEFAULT-1:0] CTRL_NOP = '0;

   // The shift-amount mode reuses imm[10:6], which is instr[10:6].
   function automatic logic [31:0] extend_imm(input logic [15:0] imm, input ext_op_e op);
      logic [31:0] res;
      res = {16'h0000, imm};
      case (op)
         EXT_SIGN:  res = {{16{imm[15]}}, imm};
         EXT_LUI:   res = {imm, 16'h0000};
         EXT_SHAMT: res = {27'h0, imm[10:6]};
         default:   res = {16'h0000, imm};
      endcase
      return res;
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection and MEM-stage forward selects; purely combinational
// so the same block can serve the EX-stage forwarder.
module hazard_detect (
   input  logic       valid_id,
   input  logic       uses_rs_id,
   input  logic       uses_rt_id,
   input  logic [4:0] rs,
   input  logic [4:0] rt,
   input  logic       valid_ex,
   input  logic       mem_read_ex,
   input  logic [4:0] dst_ex,
   input  logic       mem_wr,
   input  logic [4:0] mem_rd,
   input  logic       flush,
   output logic       stall,
   output logic       fwd_a,
   output logic       fwd_b
);

   logic hz;

   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      hz    = 1'b0;
      stall = 1'b0;
      fwd_a = 1'b0;
      fwd_b = 1'b0;

      if (valid_id && valid_ex && mem_read_ex && (dst_ex != 5'd0)) begin
         hz = (uses_rs_id && (rs == dst_ex)) || (uses_rt_id && (rt == dst_ex));
      end
      // A redirect kills the ID instruction, so there is nothing to wait for.
      stall = hz && !flush;

      // $0 reads as zero in the register file and must never be overridden.
      if (mem_wr && (mem_rd != 5'd0)) begin
         fwd_a = (mem_rd == rs);
         fwd_b = (mem_rd == rt);
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline boundary: register-file addressing, MEM forwarding, immediate
// extension, load-use bubble insertion and the saturating stall counter.
module id_ex_stage
   import cpu_pkg::*;
#(
   parameter int CTRL_W = CTRL_W_DEFAULT,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       instr_id,
   input  logic [31:0]       pc_plus4_id,
   input  logic              valid_id,
   input  logic [CTRL_W-1:0] ctrl_id,
   input  logic              mem_read_id,
   input  logic              uses_rs_id,
   input  logic              uses_rt_id,
   input  logic [4:0]        dst_id,
   input  logic [1:0]        ext_op_id,
   output logic [4:0]        addr_a,
   output logic [4:0]        addr_b,
   input  logic [31:0]       rdata_a,
   input  logic [31:0]       rdata_b,
   input  logic              mem_wr,
   input  logic [4:0]        mem_rd,
   input  logic [31:0]       mem_data,
   input  logic              flush,
   output logic              stall,
   output logic              valid_ex,
   output logic [CTRL_W-1:0] ctrl_ex,
   output logic              mem_read_ex,
   output logic [4:0]        dst_ex,
   output logic [4:0]        rs_ex,
   output logic [4:0]        rt_ex,
   output logic [31:0]       pc_plus4_ex,
   output logic [31:0]       op_a_ex,
   output logic [31:0]       op_b_ex,
   output logic [31:0]       imm_ex,
   output logic [CNT_W-1:0]  stall_count
);

   logic [4:0]  rs;
   logic [4:0]  rt;
   logic        fwd_a;
   logic        fwd_b;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [31:0] imm;
   logic        unused_opcode;

   assign rs            = instr_id[25:21];
   assign rt            = instr_id[20:16];
   assign addr_a        = rs;
   assign addr_b        = rt;
   assign unused_opcode = ^instr_id[31:26];

   hazard_detect u_hazard (
      .valid_id    (valid_id),
      .uses_rs_id  (uses_rs_id),
      .uses_rt_id  (uses_rt_id),
      .rs          (rs),
      .rt          (rt),
      .valid_ex    (valid_ex),
      .mem_read_ex (mem_read_ex),
      .dst_ex      (dst_ex),
      .mem_wr      (mem_wr),
      .mem_rd      (mem_rd),
      .flush       (flush),
      .stall       (stall),
      .fwd_a       (fwd_a),
      .fwd_b       (fwd_b)
   );

   // WB producers need no path: the register file writes on negedge.
   assign op_a = fwd_a ? mem_data : rdata_a;
   assign op_b = fwd_b ? mem_data : rdata_b;
   assign imm  = extend_imm(instr_id[15:0], ext_op_e'(ext_op_id));

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_ex    <= 1'b0;
         ctrl_ex     <= CTRL_W'(CTRL_NOP);
         mem_read_ex <= 1'b0;
         dst_ex      <= 5'd0;
         rs_ex       <= 5'd0;
         rt_ex       <= 5'd0;
         pc_plus4_ex <= 32'h0;
         op_a_ex     <= 32'h0;
         op_b_ex     <= 32'h0;
         imm_ex      <= 32'h0;
         stall_count <= '0;
      end else begin
         if (flush || stall) begin
            valid_ex    <= 1'b0;
            ctrl_ex     <= CTRL_W'(CTRL_NOP);
            mem_read_ex <= 1'b0;
            dst_ex      <= 5'd0;
            rs_ex       <= 5'd0;
            rt_ex       <= 5'd0;
            pc_plus4_ex <= 32'h0;
            op_a_ex     <= 32'h0;
            op_b_ex     <= 32'h0;
            imm_ex      <= 32'h0;
         end else begin
            valid_ex    <= valid_id;
            ctrl_ex     <= valid_id ? ctrl_id : CTRL_W'(CTRL_NOP);
            mem_read_ex <= valid_id && mem_read_id;
            dst_ex      <= valid_id ? dst_id : 5'd0;
            rs_ex       <= rs;
            rt_ex       <= rt;
            pc_plus4_ex <= pc_plus4_id;
            op_a_ex     <= op_a;
            op_b_ex     <= op_b;
            imm_ex      <= imm;
         end
         // stall already excludes flush, so a coincident redirect leaves the count alone.
         if (stall && !(&stall_count)) begin
            stall_count <= stall_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus random traffic,
// checked against a rule-level model of the EX registers and stall counters.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr_id, pc_plus4_id;
   logic        valid_id;
   logic [15:0] ctrl_id;
   logic        mem_read_id, uses_rs_id, uses_rt_id;
   logic [4:0]  dst_id;
   logic [1:0]  ext_op_id;
   logic [31:0] rdata_a, rdata_b;
   logic        mem_wr;
   logic [4:0]  mem_rd;
   logic [31:0] mem_data;
   logic        flush;

   logic [4:0]  addr_a, addr_b;
   logic        stall, valid_ex, mem_read_ex;
   logic [15:0] ctrl_ex;
   logic [4:0]  dst_ex, rs_ex, rt_ex;
   logic [31:0] pc_plus4_ex, op_a_ex, op_b_ex, imm_ex;
   logic [15:0] stall_count;

   logic [4:0]  s_addr_a, s_addr_b, s_dst_ex, s_rs_ex, s_rt_ex;
   logic        s_stall, s_valid_ex, s_mem_read_ex;
   logic [15:0] s_ctrl_ex;
   logic [31:0] s_pc_plus4_ex, s_op_a_ex, s_op_b_ex, s_imm_ex;
   logic [3:0]  s_stall_count;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        valid;
      logic [15:0] ctrl;
      logic        mem_read;
      logic [4:0]  dst, rs, rt;
      logic [31:0] pc, op_a, op_b, imm;
   } ex_t;

   ex_t         m;
   int unsigned cnt, cnt_sat;
   logic        exp_stall;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .reset(reset), .instr_id(instr_id), .pc_plus4_id(pc_plus4_id),
      .valid_id(valid_id), .ctrl_id(ctrl_id), .mem_read_id(mem_read_id),
      .uses_rs_id(uses_rs_id), .uses_rt_id(uses_rt_id), .dst_id(dst_id),
      .ext_op_id(ext_op_id), .addr_a(addr_a), .addr_b(addr_b),
      .rdata_a(rdata_a), .rdata_b(rdata_b), .mem_wr(mem_wr), .mem_rd(mem_rd),
      .mem_data(mem_data), .flush(flush), .stall(stall), .valid_ex(valid_ex),
      .ctrl_ex(ctrl_ex), .mem_read_ex(mem_read_ex), .dst_ex(dst_ex),
      .rs_ex(rs_ex), .rt_ex(rt_ex), .pc_plus4_ex(pc_plus4_ex),
      .op_a_ex(op_a_ex), .op_b_ex(op_b_ex), .imm_ex(imm_ex),
      .stall_count(stall_count)
   );

   // Narrow-counter copy on the same inputs so saturation is reachable quickly.
   id_ex_stage #(.CNT_W(4)) dut_sat (
      .clk(clk), .reset(reset), .instr_id(instr_id), .pc_plus4_id(pc_plus4_id),
      .valid_id(valid_id), .ctrl_id(ctrl_id), .mem_read_id(mem_read_id),
      .uses_rs_id(uses_rs_id), .uses_rt_id(uses_rt_id), .dst_id(dst_id),
      .ext_op_id(ext_op_id), .addr_a(s_addr_a), .addr_b(s_addr_b),
      .rdata_a(rdata_a), .rdata_b(rdata_b), .mem_wr(mem_wr), .mem_rd(mem_rd),
      .mem_data(mem_data), .flush(flush), .stall(s_stall), .valid_ex(s_valid_ex),
      .ctrl_ex(s_ctrl_ex), .mem_read_ex(s_mem_read_ex), .dst_ex(s_dst_ex),
      .rs_ex(s_rs_ex), .rt_ex(s_rt_ex), .pc_plus4_ex(s_pc_plus4_ex),
      .op_a_ex(s_op_a_ex), .op_b_ex(s_op_b_ex), .imm_ex(s_imm_ex),
      .stall_count(s_stall_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_ex();
      check("valid_ex", 32'(valid_ex), 32'(m.valid));
      check("ctrl_ex", 32'(ctrl_ex), 32'(m.ctrl));
      check("mem_read_ex", 32'(mem_read_ex), 32'(m.mem_read));
      check("dst_ex", 32'(dst_ex), 32'(m.dst));
      check("rs_ex", 32'(rs_ex), 32'(m.rs));
      check("rt_ex", 32'(rt_ex), 32'(m.rt));
      check("pc_plus4_ex", pc_plus4_ex, m.pc);
      check("op_a_ex", op_a_ex, m.op_a);
      check("op_b_ex", op_b_ex, m.op_b);
      check("imm_ex", imm_ex, m.imm);
      check("stall_count", 32'(stall_count), cnt);
      check("stall_count_sat", 32'(s_stall_count), cnt_sat);
   endtask

   task automatic model_reset();
      m = '{valid: 1'b0, ctrl: 16'h0, mem_read: 1'b0, dst: 5'd0, rs: 5'd0, rt: 5'd0,
            pc: 32'h0, op_a: 32'h0, op_b: 32'h0, imm: 32'h0};
      cnt     = 0;
      cnt_sat = 0;
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [15:0] imm16, input logic mr, input logic urs,
                         input logic urt, input logic [4:0] dst, input logic [1:0] ext);
      valid_id    = v;
      instr_id    = {6'h23, rs, rt, imm16};
      mem_read_id = mr;
      uses_rs_id  = urs;
      uses_rt_id  = urt;
      dst_id      = dst;
      ext_op_id   = ext;
      ctrl_id     = v ? 16'hA5C3 : 16'h1234;
      pc_plus4_id = 32'h8000_0104;
   endtask

   task automatic idle_mem();
      mem_wr = 1'b0; mem_rd = 5'd0; mem_data = 32'h0; flush = 1'b0;
   endtask

   // Apply the rules for one cycle: compare stall before the edge, EX after it.
   task automatic cycle();
      ex_t         nxt;
      logic [4:0]  rs, rt;
      int unsigned imm16;
      logic        hz;
      @(negedge clk);
      rs    = instr_id[25:21];
      rt    = instr_id[20:16];
      imm16 = int'(instr_id[15:0]);
      hz = valid_id && m.valid && m.mem_read && (m.dst != 0) &&
           ((uses_rs_id && rs == m.dst) || (uses_rt_id && rt == m.dst));
      exp_stall = hz && !flush;
      check("stall", 32'(stall), 32'(exp_stall));
      check("addr_a", 32'(addr_a), 32'(rs));
      check("addr_b", 32'(addr_b), 32'(rt));
      if (flush || exp_stall) begin
         nxt = '{valid: 1'b0, ctrl: 16'h0, mem_read: 1'b0, dst: 5'd0, rs: 5'd0, rt: 5'd0,
                 pc: 32'h0, op_a: 32'h0, op_b: 32'h0, imm: 32'h0};
      end else begin
         nxt.valid    = valid_id;
         nxt.ctrl     = valid_id ? ctrl_id : 16'h0;
         nxt.mem_read = valid_id ? mem_read_id : 1'b0;
         nxt.dst      = valid_id ? dst_id : 5'd0;
         nxt.rs       = rs;
         nxt.rt       = rt;
         nxt.pc       = pc_plus4_id;
         nxt.op_a     = (mem_wr && mem_rd != 0 && mem_rd == rs) ? mem_data : rdata_a;
         nxt.op_b     = (mem_wr && mem_rd != 0 && mem_rd == rt) ? mem_data : rdata_b;
         case (ext_op_id)
            2'd0:    nxt.imm = imm16;
            2'd1:    nxt.imm = (imm16 >= 32768) ? imm16 + 32'hFFFF_0000 : imm16;
            2'd2:    nxt.imm = imm16 * 65536;
            default: nxt.imm = (instr_id >> 6) % 32;
         endcase
      end
      @(posedge clk);
      #1;
      m = nxt;
      if (exp_stall) begin
         if (cnt < 65535) cnt++;
         if (cnt_sat < 15) cnt_sat++;
      end
      check_ex();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      set_id(1'b0, 5'd0, 5'd0, 16'h0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0);
      rdata_a = 32'h0; rdata_b = 32'h0;
      idle_mem();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_ex();
      check("stall_reset", 32'(stall), 32'h0);
      reset = 1'b0;

      // MEM forwarding into operand A, then the $0 exclusion.
      set_id(1'b1, 5'd5, 5'd6, 16'h0010, 1'b0, 1'b1, 1'b1, 5'd7, 2'd0);
      rdata_a = 32'h11; rdata_b = 32'h22;
      mem_wr = 1'b1; mem_rd = 5'd5; mem_data = 32'hDEAD_BEEF;
      cycle();
      check("fwd_a_direct", op_a_ex, 32'hDEAD_BEEF);
      set_id(1'b1, 5'd0, 5'd6, 16'h0010, 1'b0, 1'b1, 1'b1, 5'd7, 2'd0);
      rdata_a = 32'h0; mem_rd = 5'd0;
      cycle();
      check("fwd_zero_direct", op_a_ex, 32'h0);
      idle_mem();

      // Immediate extension modes.
      for (int e = 0; e < 4; e++) begin
         set_id(1'b1, 5'd1, 5'd2, (e == 3) ? 16'h01C0 : 16'h8001, 1'b0, 1'b0, 1'b0, 5'd3, 2'(e));
         cycle();
      end
      check("shamt_direct", imm_ex, 32'h7);

      // Load-use: lw $8 then add $9,$8,$10 -> one bubble, then the add proceeds.
      set_id(1'b1, 5'd29, 5'd8, 16'h0004, 1'b1, 1'b1, 1'b0, 5'd8, 2'd1);
      cycle();
      set_id(1'b1, 5'd8, 5'd10, 16'h0000, 1'b0, 1'b1, 1'b1, 5'd9, 2'd0);
      cycle();
      check("lu_stall_direct", 32'(exp_stall), 32'h1);
      check("lu_bubble_direct", 32'(valid_ex), 32'h0);
      check("lu_count_direct", 32'(stall_count), 32'h1);
      cycle();
      check("lu_release_direct", 32'(dst_ex), 32'd9);

      // Flush coincident with a load-use hazard.
      set_id(1'b1, 5'd29, 5'd8, 16'h0004, 1'b1, 1'b1, 1'b0, 5'd8, 2'd1);
      cycle();
      set_id(1'b1, 5'd8, 5'd10, 16'h0000, 1'b0, 1'b1, 1'b1, 5'd9, 2'd0);
      flush = 1'b1;
      cycle();
      check("flush_count_direct", 32'(stall_count), 32'h1);
      flush = 1'b0;

      // Random traffic on a narrow register range so hazards and forwards are common.
      for (int i = 0; i < 300; i++) begin
         set_id(($urandom_range(0, 7) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                5'($urandom_range(0, 3)), 2'($urandom));
         ctrl_id     = 16'($urandom);
         pc_plus4_id = $urandom;
         rdata_a     = $urandom;
         rdata_b     = $urandom;
         mem_wr      = 1'($urandom);
         mem_rd      = 5'($urandom_range(0, 3));
         mem_data    = $urandom;
         flush       = ($urandom_range(0, 9) == 0);
         cycle();
      end
      idle_mem();

      // Drive 2^4 + 3 hazards into the narrow counter copy.
      for (int i = 0; i < 19; i++) begin
         set_id(1'b1, 5'd29, 5'd8, 16'h0004, 1'b1, 1'b1, 1'b0, 5'd8, 2'd1);
         cycle();
         set_id(1'b1, 5'd10, 5'd8, 16'h0000, 1'b0, 1'b0, 1'b1, 5'd9, 2'd0);
         cycle();
      end
      check("sat_direct", 32'(s_stall_count), 32'hF);

      // Reset mid-stall with valid data in EX: everything drops without a clock edge.
      set_id(1'b1, 5'd29, 5'd8, 16'h0004, 1'b1, 1'b1, 1'b0, 5'd8, 2'd1);
      cycle();
      set_id(1'b1, 5'd8, 5'd10, 16'h0000, 1'b0, 1'b1, 1'b1, 5'd9, 2'd0);
      @(negedge clk);
      #1;
      check("pre_reset_stall", 32'(stall), 32'h1);
      reset = 1'b1;
      #1;
      model_reset();
      check("reset_stall_release", 32'(stall), 32'h0);
      check_ex();
      @(posedge clk);
      #1;
      reset = 1'b0;
      set_id(1'b0, 5'd0, 5'd0, 16'h0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0);
      cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
